// File: rtl/axi_crossbar_pkg.sv
// rtl/axi_crossbar_pkg.sv - shared types, constants and helpers for the AXI crossbar switches
//
// Contents:
//   xbar_state_e     2-bit switch FSM state (IDLE, ADDR, DATA, RESP)
//   BRESP_*          write response codes
//   lowest_set_idx   index of the lowest set bit of a vector (0 when empty)
package axi_crossbar_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ADDR = 2'b01,
    ST_DATA = 2'b10,
    ST_RESP = 2'b11
  } xbar_state_e;

  localparam logic [1:0] BRESP_OKAY   = 2'b00;
  localparam logic [1:0] BRESP_SLVERR = 2'b10;

  // Widest request vector the helper accepts; callers zero-extend into it.
  localparam int unsigned MAX_PORTS = 32;

  function automatic int unsigned lowest_set_idx(input logic [MAX_PORTS-1:0] vec);
    int unsigned idx;
    idx = 0;
    // Scan downward so the last hit is the lowest set bit.
    for (int i = MAX_PORTS - 1; i >= 0; i--) begin
      if (vec[i]) idx = unsigned'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/axi_crossbar_onehot_enc.sv
// rtl/axi_crossbar_onehot_enc.sv - lowest-set-bit encoder shared by the crossbar switches
//
// Ports:
//   vec_i    in   N      request/grant vector
//   idx_o    out  IDX_W  index of the lowest set bit of vec_i (0 when empty)
//   valid_o  out  1      vec_i has at least one bit set
module axi_crossbar_onehot_enc
  import axi_crossbar_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     vec_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  logic [MAX_PORTS-1:0] vec_ext;

  always_comb begin
    vec_ext          = '0;
    vec_ext[N-1:0]   = vec_i;
    idx_o            = IDX_W'(lowest_set_idx(vec_ext));
    valid_o          = |vec_i;
  end

endmodule

// File: rtl/axi_crossbar_wr_switch.sv
// rtl/axi_crossbar_wr_switch.sv - N-master to 1-slave AXI write-path switch behind the arbiter
//
// Holds the arbiter's grant for one complete write (AW, W beats up to WLAST, B) and routes
// the granted master's channels to the slave port through a combinational mux on sel_q.
// Optional macro AXI_CROSSBAR_WR_SWITCH_LEN_CHECK_EN adds the sticky len_err_o burst check.
//
// Ports:
//   ACLK, ARESET           clock, synchronous active-high reset
//   requests_o/arbiter_i   request vector to / one-hot grant from the arbiter
//   s_aw*/s_w*/s_b*        per-master AW/W/B channels, payloads flattened by master index
//   m_aw*/m_w*/m_b*        slave AW/W/B channels
//   len_err_o              (macro only) sticky burst-length mismatch flag
//   busy_o                 high whenever a transaction is owned
module axi_crossbar_wr_switch
  import axi_crossbar_pkg::*;
#(
  parameter int AXI_REQUEST_NUM = 4,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int LEN_WIDTH       = 8
) (
  input  logic                                   ACLK,
  input  logic                                   ARESET,
  output logic [AXI_REQUEST_NUM-1:0]             requests_o,
  input  logic [AXI_REQUEST_NUM-1:0]             arbiter_i,
  input  logic [AXI_REQUEST_NUM-1:0]             s_awvalid,
  output logic [AXI_REQUEST_NUM-1:0]             s_awready,
  input  logic [AXI_REQUEST_NUM*ADDR_WIDTH-1:0]  s_awaddr,
  input  logic [AXI_REQUEST_NUM*LEN_WIDTH-1:0]   s_awlen,
  input  logic [AXI_REQUEST_NUM-1:0]             s_wvalid,
  output logic [AXI_REQUEST_NUM-1:0]             s_wready,
  input  logic [AXI_REQUEST_NUM*DATA_WIDTH-1:0]  s_wdata,
  input  logic [AXI_REQUEST_NUM*DATA_WIDTH/8-1:0] s_wstrb,
  input  logic [AXI_REQUEST_NUM-1:0]             s_wlast,
  output logic [AXI_REQUEST_NUM-1:0]             s_bvalid,
  input  logic [AXI_REQUEST_NUM-1:0]             s_bready,
  output logic [AXI_REQUEST_NUM*2-1:0]           s_bresp,
  output logic                                   m_awvalid,
  input  logic                                   m_awready,
  output logic [ADDR_WIDTH-1:0]                  m_awaddr,
  output logic [LEN_WIDTH-1:0]                   m_awlen,
  output logic                                   m_wvalid,
  input  logic                                   m_wready,
  output logic [DATA_WIDTH-1:0]                  m_wdata,
  output logic [DATA_WIDTH/8-1:0]                m_wstrb,
  output logic                                   m_wlast,
  input  logic                                   m_bvalid,
  output logic                                   m_bready,
  input  logic [1:0]                             m_bresp,
`ifdef AXI_CROSSBAR_WR_SWITCH_LEN_CHECK_EN
  output logic                                   len_err_o,
`endif
  output logic                                   busy_o
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int IDX_W      = (AXI_REQUEST_NUM > 1) ? $clog2(AXI_REQUEST_NUM) : 1;

  xbar_state_e        state_q, state_d;
  logic [IDX_W-1:0]   sel_q, sel_d;
  logic [IDX_W-1:0]   grant_idx;
  logic               grant_vld;

  // A grant bit only counts if that master is still requesting.
  axi_crossbar_onehot_enc #(.N(AXI_REQUEST_NUM), .IDX_W(IDX_W)) u_grant_enc (
    .vec_i   (arbiter_i & s_awvalid),
    .idx_o   (grant_idx),
    .valid_o (grant_vld)
  );

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
    end
  end

  // Payloads are muxed unconditionally; only the valid/ready pairs are qualified by state.
  assign m_awaddr = s_awaddr[sel_q*ADDR_WIDTH +: ADDR_WIDTH];
  assign m_awlen  = s_awlen[sel_q*LEN_WIDTH +: LEN_WIDTH];
  assign m_wdata  = s_wdata[sel_q*DATA_WIDTH +: DATA_WIDTH];
  assign m_wstrb  = s_wstrb[sel_q*STRB_WIDTH +: STRB_WIDTH];
  assign m_wlast  = s_wlast[sel_q];
  assign s_bresp  = {AXI_REQUEST_NUM{m_bresp}};

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    requests_o = '0;
    s_awready  = '0;
    s_wready   = '0;
    s_bvalid   = '0;
    m_awvalid  = 1'b0;
    m_wvalid   = 1'b0;
    m_bready   = 1'b0;
    busy_o     = (state_q != ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        // Requests are only exposed here; zero elsewhere freezes the arbiter pointer.
        requests_o = s_awvalid;
        if (grant_vld) begin
          sel_d   = grant_idx;
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        m_awvalid        = s_awvalid[sel_q];
        s_awready[sel_q] = m_awready;
        if (s_awvalid[sel_q] && m_awready) state_d = ST_DATA;
      end
      ST_DATA: begin
        m_wvalid        = s_wvalid[sel_q];
        s_wready[sel_q] = m_wready;
        if (s_wvalid[sel_q] && m_wready && s_wlast[sel_q]) state_d = ST_RESP;
      end
      ST_RESP: begin
        s_bvalid[sel_q] = m_bvalid;
        m_bready        = s_bready[sel_q];
        if (m_bvalid && s_bready[sel_q]) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef AXI_CROSSBAR_WR_SWITCH_LEN_CHECK_EN
  logic [LEN_WIDTH:0]   beat_cnt_q;
  logic [LEN_WIDTH-1:0] awlen_q;
  logic                 len_err_q;
  logic                 aw_hs, w_hs, beat_bad;

  assign aw_hs = (state_q == ST_ADDR) && s_awvalid[sel_q] && m_awready;
  assign w_hs  = (state_q == ST_DATA) && s_wvalid[sel_q] && m_wready;
  // beat_cnt_q is the zero-based index of the beat being transferred; the last one must be awlen.
  assign beat_bad = m_wlast ? (beat_cnt_q != {1'b0, awlen_q})
                            : (beat_cnt_q >= {1'b0, awlen_q});

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      beat_cnt_q <= '0;
      awlen_q    <= '0;
      len_err_q  <= 1'b0;
    end else begin
      if (aw_hs) begin
        awlen_q    <= m_awlen;
        beat_cnt_q <= '0;
      end
      if (w_hs) begin
        beat_cnt_q <= beat_cnt_q + (LEN_WIDTH+1)'(1);
        if (beat_bad) len_err_q <= 1'b1;
      end
    end
  end

  assign len_err_o = len_err_q;
`else
  // Without the check, DATA exits on wlast alone and no beat state is kept.
`endif

endmodule
